// File: rtl/sas_arb_pkg.sv
// sas_arb_pkg: shared widths and the tag record for the sub_abs_sub arbiter.
package sas_arb_pkg;
    localparam int DATA_W   = 8;
    localparam int LAT_DEF  = 2;
    localparam int NREQ_MAX = 8;
    // Sized for the largest supported NREQ so the tag layout is fixed.
    localparam int IDX_W    = $clog2(NREQ_MAX);
    typedef struct packed {
        logic             v;
        logic [IDX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/sas_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid index at or after ptr.
module rr_pick
    import sas_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |valid;
        // Descending scan so the candidate closest to ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % NREQ]) begin
                grant = NREQ'(1) << ((int'(ptr) + k) % NREQ);
                idx   = IDX_W'((int'(ptr) + k) % NREQ);
            end
        end
    end
endmodule

// File: rtl/sas_rr_arbiter.sv
// sas_rr_arbiter: round-robin sharing of one sub_abs_sub datapath with tag-routed results.
// Optional grant counters enabled by SAS_ARB_STATS_EN.
module sas_rr_arbiter
    import sas_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LAT   = LAT_DEF
`ifdef SAS_ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_op1,
    input  logic [NREQ*DATA_W-1:0]   req_op2,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        dp_op1,
    output logic [DATA_W-1:0]        dp_op2,
    input  logic [DATA_W-1:0]        dp_res,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
`ifdef SAS_ARB_STATS_EN
    input  logic                     stat_clr,
    output logic [NREQ*CNT_W-1:0]    grant_cnt,
`endif
    output logic                     busy
);
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic             gnt;
    tag_t             tags [LAT+1];

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (en ? req_valid : '0),
        .ptr   (ptr),
        .grant (req_ready),
        .idx   (gidx),
        .any   (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_op1 <= '0;
            dp_op2 <= '0;
            ptr    <= '0;
            for (int i = 0; i <= LAT; i++) tags[i] <= '0;
        end else begin
            if (gnt) begin
                dp_op1 <= req_op1[gidx*DATA_W +: DATA_W];
                dp_op2 <= req_op2[gidx*DATA_W +: DATA_W];
                ptr    <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
            tags[0] <= '{v: gnt, idx: gidx};
            for (int i = 1; i <= LAT; i++) tags[i] <= tags[i-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= LAT; i++) busy = busy | tags[i].v;
    end

    assign rsp_valid = tags[LAT].v ? NREQ'(1) << tags[LAT].idx : '0;
    assign rsp_data  = dp_res;

`ifdef SAS_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt <= '0;
            else if (stat_clr) cnt <= '0;
            else if (req_ready[i] && cnt != '1) cnt <= cnt + 1'b1;
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif
endmodule
